// File: rtl/histeq_pkg.sv
// Shared phase encodings and m2 port sizes for the histogram-equalizer controller.
package histeq_pkg;

    localparam int M2_ADDR_W         = 16;
    localparam int M2_DATA_W         = 128;
    localparam int HIST_BINS_DEFAULT = 256;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_CLEAR = 3'd1,
        PH_COUNT = 3'd2,
        PH_CDF   = 3'd3,
        PH_MAP   = 3'd4,
        PH_DONE  = 3'd5,
        PH_ERROR = 3'd6
    } phase_t;

    function automatic logic is_wait_phase(input phase_t p);
        return (p == PH_COUNT) || (p == PH_CDF) || (p == PH_MAP);
    endfunction

endpackage

// File: rtl/histeq_sequencer_if.sv
// Job control, stage handshake and m2 scratchpad signals of the histeq sequencer.
interface histeq_sequencer_if;
    import histeq_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [2:0]           phase;

    logic                 cnt_start;
    logic                 cdf_start;
    logic                 map_start;
    logic                 cnt_done;
    logic                 cdf_done;
    logic                 map_done;

    logic [M2_ADDR_W-1:0] cnt_m2ReadAddr;
    logic [M2_ADDR_W-1:0] cnt_m2WriteAddr;
    logic [M2_DATA_W-1:0] cnt_m2WriteVal;
    logic                 cnt_m2WE;
    logic [M2_ADDR_W-1:0] cdf_m2ReadAddr;
    logic [M2_ADDR_W-1:0] cdf_m2WriteAddr;
    logic [M2_DATA_W-1:0] cdf_m2WriteVal;
    logic                 cdf_m2WE;

    logic [M2_ADDR_W-1:0] m2ReadAddr;
    logic [M2_ADDR_W-1:0] m2WriteAddr;
    logic [M2_DATA_W-1:0] m2WriteVal;
    logic                 m2WE;

    // Sequencer side.
    modport master (
        input  start, cnt_done, cdf_done, map_done,
        input  cnt_m2ReadAddr, cnt_m2WriteAddr, cnt_m2WriteVal, cnt_m2WE,
        input  cdf_m2ReadAddr, cdf_m2WriteAddr, cdf_m2WriteVal, cdf_m2WE,
        output busy, done, error, phase, cnt_start, cdf_start, map_start,
        output m2ReadAddr, m2WriteAddr, m2WriteVal, m2WE
    );

    // Stage / scratchpad side.
    modport slave (
        output start, cnt_done, cdf_done, map_done,
        output cnt_m2ReadAddr, cnt_m2WriteAddr, cnt_m2WriteVal, cnt_m2WE,
        output cdf_m2ReadAddr, cdf_m2WriteAddr, cdf_m2WriteVal, cdf_m2WE,
        input  busy, done, error, phase, cnt_start, cdf_start, map_start,
        input  m2ReadAddr, m2WriteAddr, m2WriteVal, m2WE
    );

endinterface

// File: rtl/histeq_m2_mux.sv
// Combinational m2 port selector: clear engine, count stage or CDF stage by phase.
module histeq_m2_mux
    import histeq_pkg::*;
(
    input  phase_t               phase,
    input  logic [M2_ADDR_W-1:0] clr_addr,
    input  logic [M2_ADDR_W-1:0] cnt_rd_addr,
    input  logic [M2_ADDR_W-1:0] cnt_wr_addr,
    input  logic [M2_DATA_W-1:0] cnt_wr_val,
    input  logic                 cnt_we,
    input  logic [M2_ADDR_W-1:0] cdf_rd_addr,
    input  logic [M2_ADDR_W-1:0] cdf_wr_addr,
    input  logic [M2_DATA_W-1:0] cdf_wr_val,
    input  logic                 cdf_we,
    output logic [M2_ADDR_W-1:0] m2_rd_addr,
    output logic [M2_ADDR_W-1:0] m2_wr_addr,
    output logic [M2_DATA_W-1:0] m2_wr_val,
    output logic                 m2_we
);

    always_comb begin
        m2_rd_addr = '0;
        m2_wr_addr = '0;
        m2_wr_val  = '0;
        m2_we      = 1'b0;
        case (phase)
            PH_CLEAR: begin
                m2_wr_addr = clr_addr;
                m2_we      = 1'b1;
            end
            PH_COUNT: begin
                m2_rd_addr = cnt_rd_addr;
                m2_wr_addr = cnt_wr_addr;
                m2_wr_val  = cnt_wr_val;
                m2_we      = cnt_we;
            end
            PH_CDF: begin
                m2_rd_addr = cdf_rd_addr;
                m2_wr_addr = cdf_wr_addr;
                m2_wr_val  = cdf_wr_val;
                m2_we      = cdf_we;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/histeq_sequencer.sv
// Histogram-equalizer phase controller: clear m2, count, CDF, map, with a stage watchdog.
// Optional HISTEQ_PERF_CNT_EN adds per-phase cycle counters cyc_count/cyc_cdf/cyc_map.
module histeq_sequencer
    import histeq_pkg::*;
#(
    parameter int HIST_BINS      = HIST_BINS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TMR_W          = 16
) (
    input  logic               clock,
    input  logic               rst,
`ifdef HISTEQ_PERF_CNT_EN
    output logic [31:0]        cyc_count,
    output logic [31:0]        cyc_cdf,
    output logic [31:0]        cyc_map,
`endif
    histeq_sequencer_if.master bus
);

    localparam logic [M2_ADDR_W-1:0] CLR_LAST = M2_ADDR_W'(HIST_BINS - 1);
    localparam logic [TMR_W:0]       TMO      = (TMR_W + 1)'(TIMEOUT_CYCLES);

    phase_t               state;
    logic [M2_ADDR_W-1:0] clr_addr;
    logic [TMR_W-1:0]     tmr;
    logic [TMR_W:0]       tmr_nx;
    logic                 busy_q, done_q, error_q;
    logic                 cnt_start_q, cdf_start_q, map_start_q;
    logic                 stage_done, timeout;

    // A done seen alongside the stage's own start pulse belongs to the previous job.
    always_comb begin
        tmr_nx = ({1'b0, tmr} >= TMO) ? TMO : {1'b0, tmr} + (TMR_W + 1)'(1);
        case (state)
            PH_COUNT: stage_done = bus.cnt_done && !cnt_start_q;
            PH_CDF:   stage_done = bus.cdf_done && !cdf_start_q;
            PH_MAP:   stage_done = bus.map_done && !map_start_q;
            default:  stage_done = 1'b0;
        endcase
        timeout = is_wait_phase(state) && (tmr_nx == TMO);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= PH_IDLE;
            clr_addr    <= '0;
            tmr         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cnt_start_q <= 1'b0;
            cdf_start_q <= 1'b0;
            map_start_q <= 1'b0;
`ifdef HISTEQ_PERF_CNT_EN
            cyc_count   <= '0;
            cyc_cdf     <= '0;
            cyc_map     <= '0;
`endif
        end else begin
            done_q      <= 1'b0;
            cnt_start_q <= 1'b0;
            cdf_start_q <= 1'b0;
            map_start_q <= 1'b0;
            case (state)
                PH_IDLE, PH_DONE, PH_ERROR: begin
                    if (bus.start) begin
                        state    <= PH_CLEAR;
                        busy_q   <= 1'b1;
                        error_q  <= 1'b0;
                        clr_addr <= '0;
                        tmr      <= '0;
`ifdef HISTEQ_PERF_CNT_EN
                        cyc_count <= '0;
                        cyc_cdf   <= '0;
                        cyc_map   <= '0;
`endif
                    end else if (state == PH_DONE) begin
                        state <= PH_IDLE;
                    end
                end
                PH_CLEAR: begin
                    if (clr_addr == CLR_LAST) begin
                        state       <= PH_COUNT;
                        cnt_start_q <= 1'b1;
                        clr_addr    <= '0;
                        tmr         <= '0;
                    end else begin
                        clr_addr <= clr_addr + M2_ADDR_W'(1);
                    end
                end
                PH_COUNT, PH_CDF, PH_MAP: begin
                    // tmr_nx is also the number of cycles spent in the phase so far.
                    if (stage_done) begin
                        tmr <= '0;
                        case (state)
                            PH_COUNT: begin
                                state       <= PH_CDF;
                                cdf_start_q <= 1'b1;
`ifdef HISTEQ_PERF_CNT_EN
                                cyc_count   <= 32'(tmr_nx);
`endif
                            end
                            PH_CDF: begin
                                state       <= PH_MAP;
                                map_start_q <= 1'b1;
`ifdef HISTEQ_PERF_CNT_EN
                                cyc_cdf     <= 32'(tmr_nx);
`endif
                            end
                            default: begin
                                state  <= PH_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
`ifdef HISTEQ_PERF_CNT_EN
                                cyc_map <= 32'(tmr_nx);
`endif
                            end
                        endcase
                    end else if (timeout) begin
                        state   <= PH_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr_nx[TMR_W-1:0];
                    end
                end
                default: begin
                    state  <= PH_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase     = state;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.cnt_start = cnt_start_q;
    assign bus.cdf_start = cdf_start_q;
    assign bus.map_start = map_start_q;

    histeq_m2_mux u_m2_mux (
        .phase       (state),
        .clr_addr    (clr_addr),
        .cnt_rd_addr (bus.cnt_m2ReadAddr),
        .cnt_wr_addr (bus.cnt_m2WriteAddr),
        .cnt_wr_val  (bus.cnt_m2WriteVal),
        .cnt_we      (bus.cnt_m2WE),
        .cdf_rd_addr (bus.cdf_m2ReadAddr),
        .cdf_wr_addr (bus.cdf_m2WriteAddr),
        .cdf_wr_val  (bus.cdf_m2WriteVal),
        .cdf_we      (bus.cdf_m2WE),
        .m2_rd_addr  (bus.m2ReadAddr),
        .m2_wr_addr  (bus.m2WriteAddr),
        .m2_wr_val   (bus.m2WriteVal),
        .m2_we       (bus.m2WE)
    );

endmodule
